pipe_ctrl: RTL and testbench

Central pipeline sequencer for one core of the multicore RISC-V. Combines the load-use hazard flag from decode, the taken-branch redirect from EX and the data-memory busy flag. From these it drives the PC and pipeline-register enables, the IF/ID flush and the ID/EX bubble; the bubble is the `pipeline_stall` input of the decode stage. A small FSM handles multi-cycle branch penalties, data-memory wait states and core halt. Saturating performance counters record stall and flush activity.

---
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect inputs and enable/flush outputs between pipe_ctrl and the core datapath.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use_hazard;
  logic             ex_branch_taken;
  logic             dmem_busy;
  logic             halt_req;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  load_use_hazard, ex_branch_taken, dmem_busy, halt_req,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, halted,
    output stall_cycles, flush_count
  );

  modport slave (
    output load_use_hazard, ex_branch_taken, dmem_busy, halt_req,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, halted,
    input  stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns hazard, redirect, memory-wait and halt events into
// stage enables, flush/bubble controls and saturating stall/flush counters.
module pipe_ctrl #(
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.master   io
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, HALTED} state_t;

  state_t           r_state;
  logic [3:0]       r_fcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_pc_en, w_if_id_en, w_flush, w_bubble, w_ex_mem_en, w_redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Controls are decoded from the current state and live inputs (zero latency).
  always_comb begin
    w_pc_en     = 1'b0;
    w_if_id_en  = 1'b0;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;
    w_ex_mem_en = 1'b0;
    w_redirect  = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (io.dmem_busy) begin
            // full freeze: ID/EX keeps its contents, nothing is bubbled
          end else if (io.ex_branch_taken) begin
            w_pc_en     = 1'b1;
            w_if_id_en  = 1'b1;
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_ex_mem_en = 1'b1;
            w_redirect  = 1'b1;
          end else if (io.load_use_hazard || io.halt_req) begin
            w_bubble    = 1'b1;
            w_ex_mem_en = 1'b1;
          end else begin
            w_pc_en     = 1'b1;
            w_if_id_en  = 1'b1;
            w_ex_mem_en = 1'b1;
          end
        end
        FLUSH: begin
          if (!io.dmem_busy) begin
            w_pc_en     = 1'b1;
            w_if_id_en  = 1'b1;
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_ex_mem_en = 1'b1;
          end
        end
        MEM_WAIT: begin
        end
        HALTED: begin
          w_bubble    = 1'b1;
          w_ex_mem_en = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_fcnt      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && r_state != HALTED) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_redirect)                    r_flush_cnt <= sat_inc(r_flush_cnt);
      case (r_state)
        RUN: begin
          if (io.dmem_busy) begin
            r_state <= MEM_WAIT;
          end else if (io.ex_branch_taken) begin
            if (BR_PENALTY > 1) begin
              r_state <= FLUSH;
              r_fcnt  <= 4'(BR_PENALTY - 1);
            end
          end else if (io.load_use_hazard) begin
            r_state <= RUN;
          end else if (io.halt_req) begin
            r_state <= HALTED;
          end
        end
        FLUSH: begin
          if (io.dmem_busy) begin
            r_state <= MEM_WAIT;
            r_fcnt  <= '0;
          end else if (r_fcnt <= 4'd1) begin
            r_state <= RUN;
            r_fcnt  <= '0;
          end else begin
            r_fcnt  <= r_fcnt - 4'd1;
          end
        end
        MEM_WAIT: begin
          if (!io.dmem_busy) r_state <= RUN;
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign io.pc_en        = w_pc_en;
  assign io.if_id_en     = w_if_id_en;
  assign io.if_id_flush  = w_flush;
  assign io.id_ex_bubble = w_bubble;
  assign io.ex_mem_en    = w_ex_mem_en;
  assign io.halted       = !rst && (r_state == HALTED);
  assign io.stall_cycles = rst ? '0 : r_stall_cnt;
  assign io.flush_count  = rst ? '0 : r_flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (penalty 2 / 4-bit counters, penalty 3 / 32-bit
// counters) driven in lockstep and compared every cycle against an action-level model.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lu = 1'b0, br = 1'b0, bz = 1'b0, hr = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(4))  if_a ();
  pipe_ctrl_if #(.CNT_W(32)) if_b ();

  assign if_a.load_use_hazard = lu;
  assign if_a.ex_branch_taken = br;
  assign if_a.dmem_busy       = bz;
  assign if_a.halt_req        = hr;
  assign if_b.load_use_hazard = lu;
  assign if_b.ex_branch_taken = br;
  assign if_b.dmem_busy       = bz;
  assign if_b.halt_req        = hr;

  pipe_ctrl #(.BR_PENALTY(2), .CNT_W(4))  u_a (.clk(clk), .rst(rst), .io(if_a));
  pipe_ctrl #(.BR_PENALTY(3), .CNT_W(32)) u_b (.clk(clk), .rst(rst), .io(if_b));

  localparam int S_RUN = 0, S_FLUSH = 1, S_WAIT = 2, S_HALT = 3;
  localparam int A_ZERO = 0, A_FREEZE = 1, A_SQUASH = 2, A_HOLD = 3, A_GO = 4;

  typedef struct {
    int     st;
    int     rem;
    longint stall;
    longint fl;
  } mdl_t;

  mdl_t ma, mb;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // What the pipeline is told to do this cycle, from the rules for each mode.
  function automatic int mdl_act(mdl_t m, logic r, logic l, logic b, logic z, logic h);
    if (r) return A_ZERO;
    case (m.st)
      S_RUN:   return z ? A_FREEZE : b ? A_SQUASH : (l || h) ? A_HOLD : A_GO;
      S_FLUSH: return z ? A_FREEZE : A_SQUASH;
      S_WAIT:  return A_FREEZE;
      default: return A_HOLD;
    endcase
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, logic r, logic l, logic b, logic z, logic h,
                                    int pen, longint cmax);
    mdl_t n;
    int   act;
    n   = m;
    act = mdl_act(m, r, l, b, z, h);
    if (r) begin
      n.st = S_RUN; n.rem = 0; n.stall = 0; n.fl = 0;
      return n;
    end
    if ((act == A_FREEZE || act == A_HOLD) && m.st != S_HALT && m.stall < cmax)
      n.stall = m.stall + 1;
    if (m.st == S_RUN && act == A_SQUASH && m.fl < cmax) n.fl = m.fl + 1;
    case (m.st)
      S_RUN: begin
        if (z)                   n.st = S_WAIT;
        else if (b && pen > 1) begin n.st = S_FLUSH; n.rem = pen - 1; end
        else if (!b && !l && h)  n.st = S_HALT;
      end
      S_FLUSH: begin
        if (z)               n.st = S_WAIT;
        else if (m.rem == 1) n.st = S_RUN;
        else                 n.rem = m.rem - 1;
      end
      S_WAIT:  if (!z) n.st = S_RUN;
      default: n.st = S_HALT;
    endcase
    return n;
  endfunction

  task automatic chk_dut(input string nm, input mdl_t m, input logic r,
                         input logic pc, input logic ifid, input logic fl, input logic bub,
                         input logic exm, input logic hlt, input logic [63:0] sc,
                         input logic [63:0] fc);
    int act;
    act = mdl_act(m, r, lu, br, bz, hr);
    chk({nm, ".pc_en"},        {63'd0, pc},   {63'd0, act == A_SQUASH || act == A_GO});
    chk({nm, ".if_id_en"},     {63'd0, ifid}, {63'd0, act == A_SQUASH || act == A_GO});
    chk({nm, ".if_id_flush"},  {63'd0, fl},   {63'd0, act == A_SQUASH});
    chk({nm, ".id_ex_bubble"}, {63'd0, bub},  {63'd0, act == A_SQUASH || act == A_HOLD});
    chk({nm, ".ex_mem_en"},    {63'd0, exm},  {63'd0, act == A_SQUASH || act == A_HOLD || act == A_GO});
    chk({nm, ".halted"},       {63'd0, hlt},  {63'd0, !r && m.st == S_HALT});
    chk({nm, ".stall_cycles"}, sc, r ? 64'd0 : 64'(m.stall));
    chk({nm, ".flush_count"},  fc, r ? 64'd0 : 64'(m.fl));
  endtask

  task automatic step(input logic r, input logic l, input logic b, input logic z, input logic h);
    @(posedge clk);
    #1;
    rst = r; lu = l; br = b; bz = z; hr = h;
    #4;
    chk_dut("A", ma, r, if_a.pc_en, if_a.if_id_en, if_a.if_id_flush, if_a.id_ex_bubble,
            if_a.ex_mem_en, if_a.halted, {60'd0, if_a.stall_cycles}, {60'd0, if_a.flush_count});
    chk_dut("B", mb, r, if_b.pc_en, if_b.if_id_en, if_b.if_id_flush, if_b.id_ex_bubble,
            if_b.ex_mem_en, if_b.halted, {32'd0, if_b.stall_cycles}, {32'd0, if_b.flush_count});
    ma = mdl_next(ma, r, l, b, z, h, 2, 64'd15);
    mb = mdl_next(mb, r, l, b, z, h, 3, 64'hFFFF_FFFF);
  endtask

  initial begin
    int halt_age;
    ma = '{st: S_RUN, rem: 0, stall: 0, fl: 0};
    mb = '{st: S_RUN, rem: 0, stall: 0, fl: 0};

    // reset, then idle
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    // single load-use stall
    step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    // taken branch with multi-cycle penalty
    step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // memory wait overlapping a load-use hazard
    repeat (3) step(0, 1, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    // busy and branch together, branch re-presented after the wait
    step(0, 0, 1, 1, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // halt, later branch ignored, then reset
    step(0, 0, 0, 0, 1); step(0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 1, 1, 1);
    chk("halt_held", {63'd0, if_a.halted}, 64'd1);
    step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);

    // randomized traffic, with occasional resets and forced exit from halt
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, l, b, z, h;
      halt_age = (ma.st == S_HALT || mb.st == S_HALT) ? halt_age + 1 : 0;
      r = ($urandom_range(0, 99) < 1) || (halt_age > 6);
      l = $urandom_range(0, 99) < 20;
      b = $urandom_range(0, 99) < 15;
      z = $urandom_range(0, 99) < 20;
      h = $urandom_range(0, 99) < 3;
      step(r, l, b, z, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
